acc_rsp_buffer: RTL and testbench

ACC_RSP_BUFFER -- requirements
Module: acc_rsp_buffer

---
 rtl/acc_pkg.sv | 22 ++
 rtl/acc_rsp_buffer_if.sv | 37 +++
 rtl/fifo_v3.sv | 55 +++++
 rtl/acc_rsp_buffer.sv | 131 +++++++++++++
 tb/tb_acc_rsp_buffer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared types for the accelerator response buffer
package acc_pkg;

  // Storage fields are sized for the widest supported configuration.
  localparam int AccMaxDataWidth = 64;
  localparam int AccMaxIdWidth   = 16;

  typedef enum logic [1:0] {
    WbIdle   = 2'd0,
    WbFirst  = 2'd1,
    WbSecond = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [AccMaxDataWidth-1:0] data0;
    logic [AccMaxDataWidth-1:0] data1;
    logic                       dual;
    logic [AccMaxIdWidth-1:0]   id;
    logic                       error;
  } rsp_entry_t;

endpackage

// File: rtl/acc_rsp_buffer_if.sv
// rtl/acc_rsp_buffer_if.sv - request, response and writeback handshakes of the response buffer
interface acc_rsp_buffer_if #(
  parameter int DataWidth = 32,
  parameter int IdWidth   = 5
);
  logic                 adp_q_valid_i;
  logic                 adp_q_ready_o;
  logic                 ic_q_valid_o;
  logic                 ic_q_ready_i;
  logic                 ic_p_valid_i;
  logic                 ic_p_ready_o;
  logic [DataWidth-1:0] ic_p_data0_i;
  logic [DataWidth-1:0] ic_p_data1_i;
  logic                 ic_p_dual_i;
  logic [IdWidth-1:0]   ic_p_id_i;
  logic                 ic_p_error_i;
  logic                 wb_valid_o;
  logic                 wb_ready_i;
  logic [DataWidth-1:0] wb_data_o;
  logic [IdWidth-1:0]   wb_id_o;
  logic                 wb_error_o;

  modport slave (
    input  adp_q_valid_i, ic_q_ready_i, ic_p_valid_i, ic_p_data0_i, ic_p_data1_i,
           ic_p_dual_i, ic_p_id_i, ic_p_error_i, wb_ready_i,
    output adp_q_ready_o, ic_q_valid_o, ic_p_ready_o, wb_valid_o, wb_data_o,
           wb_id_o, wb_error_o
  );

  modport master (
    output adp_q_valid_i, ic_q_ready_i, ic_p_valid_i, ic_p_data0_i, ic_p_data1_i,
           ic_p_dual_i, ic_p_id_i, ic_p_error_i, wb_ready_i,
    input  adp_q_ready_o, ic_q_valid_o, ic_p_ready_o, wb_valid_o, wb_data_o,
           wb_id_o, wb_error_o
  );

endinterface

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - registered-output FIFO without fall-through, head exposed on data_o
module fifo_v3 #(
  parameter int  DEPTH = 4,
  parameter type dtype = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  dtype                       data_i,
  input  logic                       pop_i,
  output dtype                       data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] usage_o
);

  localparam int AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CntW  = $clog2(DEPTH + 1);

  dtype             mem_q [DEPTH];
  logic [AddrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             push_en, pop_en;

  function automatic logic [AddrW-1:0] wrap_inc(input logic [AddrW-1:0] p);
    return (p == AddrW'(DEPTH - 1)) ? '0 : p + AddrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign usage_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Pop is only honoured on a stored entry, so data never falls through.
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wrap_inc(wr_ptr_q);
      if (pop_en)  rd_ptr_q <= wrap_inc(rd_ptr_q);
      if (push_en && !pop_en)      cnt_q <= cnt_q + CntW'(1);
      else if (pop_en && !push_en) cnt_q <= cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/acc_rsp_buffer.sv
// rtl/acc_rsp_buffer.sv - credit-gated accelerator response buffer with dual-beat writeback
module acc_rsp_buffer
  import acc_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int IdWidth   = 5,
  parameter int Depth     = 4,
  parameter bit DualWb    = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  acc_rsp_buffer_if.slave            bus,
  output logic [$clog2(Depth+1)-1:0] outstanding_o,
  output logic                       spurious_o
);

  localparam int CntW = $clog2(Depth + 1);

  wb_state_e         state_q;
  logic [CntW-1:0]   outstanding_q, outstanding_d;
  logic              spurious_q, spurious_d;

  rsp_entry_t        push_entry, head;
  logic              fifo_full, fifo_empty;
  logic [CntW-1:0]   fifo_usage;
  logic              avail, issue, push, pop, wb_hs, more_after_pop;
  logic [IdWidth-1:0] head_id;

  // Credit gating: requests only pass while a FIFO slot is reserved for the answer.
  assign avail             = (outstanding_q < CntW'(Depth));
  assign bus.ic_q_valid_o  = bus.adp_q_valid_i & avail;
  assign bus.adp_q_ready_o = bus.ic_q_ready_i & avail;
  assign issue             = bus.ic_q_valid_o & bus.ic_q_ready_i;

  assign bus.ic_p_ready_o = ~fifo_full;
  assign push             = bus.ic_p_valid_i & bus.ic_p_ready_o;

  always_comb begin
    push_entry       = '0;
    push_entry.data0 = AccMaxDataWidth'(bus.ic_p_data0_i);
    push_entry.data1 = AccMaxDataWidth'(bus.ic_p_data1_i);
    push_entry.dual  = bus.ic_p_dual_i & DualWb;
    push_entry.id    = AccMaxIdWidth'(bus.ic_p_id_i);
    push_entry.error = bus.ic_p_error_i;
  end

  fifo_v3 #(
    .DEPTH (Depth),
    .dtype (rsp_entry_t)
  ) i_fifo (
    .clk_i   (clk),
    .rst_ni  (~rst_n),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage)
  );

  assign bus.wb_valid_o = (state_q != WbIdle);
  assign wb_hs          = bus.wb_valid_o & bus.wb_ready_i;
  assign pop            = wb_hs & ((state_q == WbSecond) | ((state_q == WbFirst) & ~head.dual));
  // A same-cycle push refills the head slot, so the next beat follows without a bubble.
  assign more_after_pop = (fifo_usage > CntW'(1)) | push;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= WbIdle;
    end else begin
      case (state_q)
        WbIdle:   if (push || !fifo_empty) state_q <= WbFirst;
        WbFirst:  if (wb_hs) state_q <= head.dual ? WbSecond : (more_after_pop ? WbFirst : WbIdle);
        WbSecond: if (wb_hs) state_q <= more_after_pop ? WbFirst : WbIdle;
        default:  state_q <= WbIdle;
      endcase
    end
  end

  assign head_id = IdWidth'(head.id);

  always_comb begin
    bus.wb_data_o  = '0;
    bus.wb_id_o    = '0;
    bus.wb_error_o = 1'b0;
    case (state_q)
      WbFirst: begin
        bus.wb_data_o  = DataWidth'(head.data0);
        bus.wb_id_o    = head_id;
        bus.wb_error_o = head.error;
      end
      WbSecond: begin
        bus.wb_data_o  = DataWidth'(head.data1);
        bus.wb_id_o    = head_id + IdWidth'(1);
        bus.wb_error_o = head.error;
      end
      default: ;
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (issue && !pop && outstanding_q != CntW'(Depth))
      outstanding_d = outstanding_q + CntW'(1);
    else if (pop && !issue && outstanding_q != '0)
      outstanding_d = outstanding_q - CntW'(1);
    spurious_d = spurious_q | (push & (outstanding_q == '0));
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      outstanding_q <= '0;
      spurious_q    <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      spurious_q    <= spurious_d;
    end
  end

  assign outstanding_o = outstanding_q;
  assign spurious_o    = spurious_q;

  a_wb_stable: assert property (@(posedge clk) disable iff (rst_n)
    (bus.wb_valid_o && !bus.wb_ready_i) |=>
      (bus.wb_valid_o && $stable(bus.wb_data_o) && $stable(bus.wb_id_o) && $stable(bus.wb_error_o)));

  a_no_overflow: assert property (@(posedge clk) disable iff (rst_n)
    bus.ic_p_valid_i |-> bus.ic_p_ready_o);

endmodule

// File: tb/tb_acc_rsp_buffer.sv
// tb/tb_acc_rsp_buffer.sv - directed self-checking bench for acc_rsp_buffer
module tb_acc_rsp_buffer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] outstanding;
  logic       spurious;
  int         checks = 0;
  int         failures = 0;

  acc_rsp_buffer_if #(.DataWidth(32), .IdWidth(5)) bus_if ();

  acc_rsp_buffer #(
    .DataWidth (32),
    .IdWidth   (5),
    .Depth     (4),
    .DualWb    (1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus_if.slave),
    .outstanding_o (outstanding),
    .spurious_o    (spurious)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus_if.adp_q_valid_i = 1'b0;
    bus_if.ic_q_ready_i  = 1'b0;
    bus_if.ic_p_valid_i  = 1'b0;
    bus_if.ic_p_data0_i  = '0;
    bus_if.ic_p_data1_i  = '0;
    bus_if.ic_p_dual_i   = 1'b0;
    bus_if.ic_p_id_i     = '0;
    bus_if.ic_p_error_i  = 1'b0;
    bus_if.wb_ready_i    = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic issue_n(input int n);
    bus_if.adp_q_valid_i = 1'b1;
    bus_if.ic_q_ready_i  = 1'b1;
    repeat (n) @(negedge clk);
    bus_if.adp_q_valid_i = 1'b0;
  endtask

  task automatic send_rsp(input logic [31:0] d0, input logic [31:0] d1, input logic dual,
                          input logic [4:0] id, input logic err);
    bus_if.ic_p_valid_i = 1'b1;
    bus_if.ic_p_data0_i = d0;
    bus_if.ic_p_data1_i = d1;
    bus_if.ic_p_dual_i  = dual;
    bus_if.ic_p_id_i    = id;
    bus_if.ic_p_error_i = err;
  endtask

  task automatic test_reset();
    clear_inputs();
    repeat (2) @(negedge clk);
    checks++; if (bus_if.wb_valid_o !== 1'b0) begin failures++; $display("FAIL rst_wb_valid got=%0h exp=0", bus_if.wb_valid_o); end
    checks++; if (bus_if.wb_data_o !== 32'h0) begin failures++; $display("FAIL rst_wb_data got=%0h exp=0", bus_if.wb_data_o); end
    checks++; if (bus_if.wb_id_o !== 5'h0) begin failures++; $display("FAIL rst_wb_id got=%0h exp=0", bus_if.wb_id_o); end
    checks++; if (bus_if.wb_error_o !== 1'b0) begin failures++; $display("FAIL rst_wb_error got=%0h exp=0", bus_if.wb_error_o); end
    checks++; if (bus_if.ic_p_ready_o !== 1'b1) begin failures++; $display("FAIL rst_ic_p_ready got=%0h exp=1", bus_if.ic_p_ready_o); end
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL rst_outstanding got=%0d exp=0", outstanding); end
    checks++; if (spurious !== 1'b0) begin failures++; $display("FAIL rst_spurious got=%0h exp=0", spurious); end
    bus_if.ic_q_ready_i = 1'b1;
    #1;
    checks++; if (bus_if.adp_q_ready_o !== 1'b1) begin failures++; $display("FAIL rst_adp_ready_hi got=%0h exp=1", bus_if.adp_q_ready_o); end
    bus_if.ic_q_ready_i = 1'b0;
    #1;
    checks++; if (bus_if.adp_q_ready_o !== 1'b0) begin failures++; $display("FAIL rst_adp_ready_lo got=%0h exp=0", bus_if.adp_q_ready_o); end
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    bus_if.adp_q_valid_i = 1'b1;
    bus_if.ic_q_ready_i  = 1'b1;
    #1;
    checks++; if (bus_if.ic_q_valid_o !== 1'b1) begin failures++; $display("FAIL single_ic_q_valid got=%0h exp=1", bus_if.ic_q_valid_o); end
    @(negedge clk);
    bus_if.adp_q_valid_i = 1'b0;
    checks++; if (outstanding !== 3'd1) begin failures++; $display("FAIL single_out_1 got=%0d exp=1", outstanding); end
    send_rsp(32'hDEADBEEF, 32'h0, 1'b0, 5'd3, 1'b0);
    @(negedge clk);
    bus_if.ic_p_valid_i = 1'b0;
    checks++; if (bus_if.wb_valid_o !== 1'b1) begin failures++; $display("FAIL single_wb_valid got=%0h exp=1", bus_if.wb_valid_o); end
    checks++; if (bus_if.wb_data_o !== 32'hDEADBEEF) begin failures++; $display("FAIL single_wb_data got=%0h exp=deadbeef", bus_if.wb_data_o); end
    checks++; if (bus_if.wb_id_o !== 5'd3) begin failures++; $display("FAIL single_wb_id got=%0d exp=3", bus_if.wb_id_o); end
    bus_if.wb_ready_i = 1'b1;
    @(negedge clk);
    checks++; if (bus_if.wb_valid_o !== 1'b0) begin failures++; $display("FAIL single_wb_done got=%0h exp=0", bus_if.wb_valid_o); end
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL single_out_0 got=%0d exp=0", outstanding); end
  endtask

  task automatic test_dual();
    apply_reset();
    issue_n(1);
    send_rsp(32'h11, 32'h22, 1'b1, 5'd31, 1'b0);
    @(negedge clk);
    bus_if.ic_p_valid_i = 1'b0;
    checks++; if (bus_if.wb_data_o !== 32'h11 || bus_if.wb_id_o !== 5'd31) begin failures++; $display("FAIL dual_beat0 got=%0h/%0d exp=11/31", bus_if.wb_data_o, bus_if.wb_id_o); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus_if.wb_valid_o !== 1'b1 || bus_if.wb_data_o !== 32'h11 || bus_if.wb_id_o !== 5'd31) begin
        failures++; $display("FAIL dual_stall%0d got=%0h/%0h/%0d exp=1/11/31", i, bus_if.wb_valid_o, bus_if.wb_data_o, bus_if.wb_id_o);
      end
    end
    bus_if.wb_ready_i = 1'b1;
    @(negedge clk);
    checks++; if (bus_if.wb_valid_o !== 1'b1 || bus_if.wb_data_o !== 32'h22 || bus_if.wb_id_o !== 5'd0) begin failures++; $display("FAIL dual_beat1 got=%0h/%0h/%0d exp=1/22/0", bus_if.wb_valid_o, bus_if.wb_data_o, bus_if.wb_id_o); end
    checks++; if (outstanding !== 3'd1) begin failures++; $display("FAIL dual_out_mid got=%0d exp=1", outstanding); end
    @(negedge clk);
    checks++; if (bus_if.wb_valid_o !== 1'b0 || outstanding !== 3'd0) begin failures++; $display("FAIL dual_done got=%0h/%0d exp=0/0", bus_if.wb_valid_o, outstanding); end
  endtask

  task automatic test_credit_limit();
    apply_reset();
    bus_if.adp_q_valid_i = 1'b1;
    bus_if.ic_q_ready_i  = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (outstanding !== 3'd4) begin failures++; $display("FAIL credit_out_4 got=%0d exp=4", outstanding); end
    checks++; if (bus_if.ic_q_valid_o !== 1'b0 || bus_if.adp_q_ready_o !== 1'b0) begin failures++; $display("FAIL credit_blocked got=%0h/%0h exp=0/0", bus_if.ic_q_valid_o, bus_if.adp_q_ready_o); end
    send_rsp(32'h55, 32'h0, 1'b0, 5'd1, 1'b0);
    bus_if.wb_ready_i = 1'b1;
    @(negedge clk);
    bus_if.ic_p_valid_i = 1'b0;
    checks++; if (bus_if.wb_valid_o !== 1'b1 || bus_if.ic_q_valid_o !== 1'b0) begin failures++; $display("FAIL credit_beat got=%0h/%0h exp=1/0", bus_if.wb_valid_o, bus_if.ic_q_valid_o); end
    @(negedge clk);
    checks++; if (outstanding !== 3'd3 || bus_if.ic_q_valid_o !== 1'b1 || bus_if.adp_q_ready_o !== 1'b1) begin failures++; $display("FAIL credit_free got=%0d/%0h/%0h exp=3/1/1", outstanding, bus_if.ic_q_valid_o, bus_if.adp_q_ready_o); end
    @(negedge clk);
    bus_if.adp_q_valid_i = 1'b0;
    checks++; if (outstanding !== 3'd4) begin failures++; $display("FAIL credit_fifth_issued got=%0d exp=4", outstanding); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    issue_n(2);
    checks++; if (outstanding !== 3'd2) begin failures++; $display("FAIL simul_out_pre got=%0d exp=2", outstanding); end
    bus_if.wb_ready_i = 1'b1;
    send_rsp(32'h77, 32'h0, 1'b0, 5'd5, 1'b0);
    @(negedge clk);
    bus_if.ic_p_valid_i  = 1'b0;
    bus_if.adp_q_valid_i = 1'b1;
    #1;
    checks++; if (bus_if.wb_valid_o !== 1'b1 || bus_if.ic_q_valid_o !== 1'b1) begin failures++; $display("FAIL simul_both got=%0h/%0h exp=1/1", bus_if.wb_valid_o, bus_if.ic_q_valid_o); end
    @(negedge clk);
    bus_if.adp_q_valid_i = 1'b0;
    checks++; if (outstanding !== 3'd2) begin failures++; $display("FAIL simul_out_post got=%0d exp=2", outstanding); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    issue_n(2);
    bus_if.wb_ready_i = 1'b1;
    send_rsp(32'hA1, 32'h0, 1'b0, 5'd8, 1'b0);
    @(negedge clk);
    send_rsp(32'hA2, 32'h0, 1'b0, 5'd9, 1'b0);
    checks++; if (bus_if.wb_valid_o !== 1'b1 || bus_if.wb_data_o !== 32'hA1 || bus_if.wb_id_o !== 5'd8) begin failures++; $display("FAIL b2b_first got=%0h/%0h/%0d exp=1/a1/8", bus_if.wb_valid_o, bus_if.wb_data_o, bus_if.wb_id_o); end
    @(negedge clk);
    bus_if.ic_p_valid_i = 1'b0;
    checks++; if (bus_if.wb_valid_o !== 1'b1 || bus_if.wb_data_o !== 32'hA2 || bus_if.wb_id_o !== 5'd9) begin failures++; $display("FAIL b2b_second got=%0h/%0h/%0d exp=1/a2/9", bus_if.wb_valid_o, bus_if.wb_data_o, bus_if.wb_id_o); end
    @(negedge clk);
    checks++; if (bus_if.wb_valid_o !== 1'b0 || outstanding !== 3'd0) begin failures++; $display("FAIL b2b_done got=%0h/%0d exp=0/0", bus_if.wb_valid_o, outstanding); end
  endtask

  task automatic test_spurious();
    apply_reset();
    send_rsp(32'hCAFE, 32'h0, 1'b0, 5'd7, 1'b1);
    @(negedge clk);
    bus_if.ic_p_valid_i = 1'b0;
    checks++; if (spurious !== 1'b1) begin failures++; $display("FAIL spur_set got=%0h exp=1", spurious); end
    checks++; if (bus_if.wb_valid_o !== 1'b1 || bus_if.wb_data_o !== 32'hCAFE || bus_if.wb_id_o !== 5'd7 || bus_if.wb_error_o !== 1'b1) begin failures++; $display("FAIL spur_beat got=%0h/%0h/%0d/%0h exp=1/cafe/7/1", bus_if.wb_valid_o, bus_if.wb_data_o, bus_if.wb_id_o, bus_if.wb_error_o); end
    bus_if.wb_ready_i = 1'b1;
    @(negedge clk);
    checks++; if (bus_if.wb_valid_o !== 1'b0 || outstanding !== 3'd0) begin failures++; $display("FAIL spur_retire got=%0h/%0d exp=0/0", bus_if.wb_valid_o, outstanding); end
    issue_n(1);
    checks++; if (spurious !== 1'b1 || outstanding !== 3'd1) begin failures++; $display("FAIL spur_sticky got=%0h/%0d exp=1/1", spurious, outstanding); end
    apply_reset();
    checks++; if (spurious !== 1'b0) begin failures++; $display("FAIL spur_cleared got=%0h exp=0", spurious); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    issue_n(3);
    send_rsp(32'h100, 32'h101, 1'b1, 5'd2, 1'b0);
    @(negedge clk);
    send_rsp(32'h200, 32'h0, 1'b0, 5'd4, 1'b0);
    @(negedge clk);
    send_rsp(32'h300, 32'h0, 1'b0, 5'd6, 1'b0);
    @(negedge clk);
    bus_if.ic_p_valid_i = 1'b0;
    bus_if.wb_ready_i   = 1'b1;
    @(negedge clk);
    bus_if.wb_ready_i = 1'b0;
    checks++; if (bus_if.wb_valid_o !== 1'b1 || bus_if.wb_data_o !== 32'h101 || bus_if.wb_id_o !== 5'd3) begin failures++; $display("FAIL mid_second got=%0h/%0h/%0d exp=1/101/3", bus_if.wb_valid_o, bus_if.wb_data_o, bus_if.wb_id_o); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus_if.wb_valid_o !== 1'b0 || outstanding !== 3'd0) begin failures++; $display("FAIL mid_async got=%0h/%0d exp=0/0", bus_if.wb_valid_o, outstanding); end
    @(negedge clk);
    rst_n = 1'b0;
    bus_if.wb_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus_if.wb_valid_o !== 1'b0) begin failures++; $display("FAIL mid_no_beat%0d got=%0h exp=0", i, bus_if.wb_valid_o); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_credit_limit();
    test_simultaneous();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
